// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake between a UART/debug byte source and the boot loader.
//   byte_valid_i : source has a byte on byte_i
//   byte_i       : stream byte
//   byte_ready_o : loader accepts the byte this cycle
// Modports: master = byte source, slave = loader.
interface imem_boot_loader_if;
  logic       byte_valid_i;
  logic [7:0] byte_i;
  logic       byte_ready_o;

  modport master (output byte_valid_i, output byte_i, input byte_ready_o);
  modport slave  (input byte_valid_i, input byte_i, output byte_ready_o);
endinterface

// File: rtl/imem_boot_loader.sv
// Boot-time instruction memory loader. Takes a byte stream (word count N,
// then N little-endian 32-bit words), writes each word to instruction memory
// at consecutive byte addresses from BASE_ADDR, and holds the core in reset
// until the image is in place.
// Optional feature (macro LOADER_CSUM_EN): a trailing 4-byte checksum equal to
// the mod-2^32 sum of all words must match, otherwise the load is aborted.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : begin a load (honoured in IDLE, DONE, ERR)
//   bs           : byte stream (slave modport)
//   wr_en_o      : one-cycle memory write strobe
//   wr_addr_o    : byte address of the word being written
//   wr_data_o    : word being written
//   cpu_rst_o    : core reset hold
//   done_o       : image loaded successfully
//   err_o        : load aborted
module imem_boot_loader #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_DEPTH = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  imem_boot_loader_if.slave bs,
  output logic              wr_en_o,
  output logic [DATA_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = $clog2(ADDR_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
`ifdef LOADER_CSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

  state_t            state;
  logic [1:0]        bcnt;
  logic [23:0]       sreg;
  logic [CNT_W-1:0]  n_words;
  logic [CNT_W-1:0]  wcnt;
  logic [DATA_W-1:0] waddr;
  logic              byte_ready;
`ifdef LOADER_CSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  logic              xfer_c;
  logic              load_c;
  logic [DATA_W-1:0] word_c;

  assign bs.byte_ready_o = byte_ready;
  assign xfer_c = bs.byte_valid_i & byte_ready;
  // Completed word when the current byte is the 4th of a group.
  assign word_c = {bs.byte_i, sreg};
  assign load_c = start_i && (state == IDLE || state == DONE || state == ERR);

  // Loader FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bcnt       <= '0;
      sreg       <= '0;
      n_words    <= '0;
      wcnt       <= '0;
      waddr      <= BASE_ADDR;
      byte_ready <= 1'b0;
      wr_en_o    <= 1'b0;
      wr_addr_o  <= BASE_ADDR;
      wr_data_o  <= '0;
      cpu_rst_o  <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
`ifdef LOADER_CSUM_EN
      sum        <= '0;
`endif
    end else begin
      wr_en_o <= 1'b0;
      if (load_c) begin
        // Fresh load: core back into reset, counters and address restart.
        state      <= HDR;
        bcnt       <= '0;
        sreg       <= '0;
        wcnt       <= '0;
        waddr      <= BASE_ADDR;
        byte_ready <= 1'b1;
        cpu_rst_o  <= 1'b1;
        done_o     <= 1'b0;
        err_o      <= 1'b0;
`ifdef LOADER_CSUM_EN
        sum        <= '0;
`endif
      end else begin
        case (state)
          HDR: begin
            if (xfer_c) begin
              bcnt <= bcnt + 2'd1;
              sreg <= {bs.byte_i, sreg[23:8]};
              if (bcnt == 2'd3) begin
                n_words <= word_c[CNT_W-1:0];
                if (word_c > DATA_W'(ADDR_DEPTH)) begin
                  state      <= ERR;
                  byte_ready <= 1'b0;
                  err_o      <= 1'b1;
                end else if (word_c == '0) begin
`ifdef LOADER_CSUM_EN
                  state      <= CSUM;
`else
                  state      <= DONE;
                  byte_ready <= 1'b0;
                  done_o     <= 1'b1;
`endif
                end else begin
                  state <= DATA;
                end
              end
            end
          end
          DATA: begin
            if (xfer_c) begin
              bcnt <= bcnt + 2'd1;
              sreg <= {bs.byte_i, sreg[23:8]};
              if (bcnt == 2'd3) begin
                wr_en_o   <= 1'b1;
                wr_data_o <= word_c;
                wr_addr_o <= waddr;
                waddr     <= waddr + DATA_W'(4);
                wcnt      <= wcnt + CNT_W'(1);
`ifdef LOADER_CSUM_EN
                sum       <= sum + word_c;
`endif
                if (wcnt == n_words - CNT_W'(1)) begin
`ifdef LOADER_CSUM_EN
                  state      <= CSUM;
`else
                  state      <= DONE;
                  byte_ready <= 1'b0;
                  done_o     <= 1'b1;
`endif
                end
              end
            end
          end
`ifdef LOADER_CSUM_EN
          CSUM: begin
            if (xfer_c) begin
              bcnt <= bcnt + 2'd1;
              sreg <= {bs.byte_i, sreg[23:8]};
              if (bcnt == 2'd3) begin
                byte_ready <= 1'b0;
                if (word_c == sum) begin
                  state  <= DONE;
                  done_o <= 1'b1;
                end else begin
                  state <= ERR;
                  err_o <= 1'b1;
                end
              end
            end
          end
`endif
          // Release the core one cycle after done_o rises.
          DONE:    cpu_rst_o <= 1'b0;
          ERR:     cpu_rst_o <= 1'b1;
          IDLE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed, table-driven bench for imem_boot_loader: each table row is one
// complete load with hand-computed expected writes and final status; the
// mid-load reset and full-depth image are hand-written sequences.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst;
  logic        done;
  logic        err;

  imem_boot_loader_if bif ();

  imem_boot_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .bs       (bif),
    .wr_en_o  (wr_en),
    .wr_addr_o(wr_addr),
    .wr_data_o(wr_data),
    .cpu_rst_o(cpu_rst),
    .done_o   (done),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       hdr;
    int                nw;
    logic [2:0][31:0]  w;
    logic [31:0]       csum;
    bit                gap;
    bit                hdr_err;
    bit                exp_done;
    bit                exp_err;
    int                exp_wr;
  } vec_t;

`ifdef LOADER_CSUM_EN
  localparam int NVEC = 8;
`else
  localparam int NVEC = 6;
`endif

  vec_t        vecs[NVEC];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          ready_ok;
  bit          tmo;

  // Capture every write strobe away from the active edge.
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
  end

  function automatic vec_t make_vec(input logic [31:0] hdr, input int nw,
                                    input logic [31:0] w0, input logic [31:0] w1,
                                    input logic [31:0] w2, input logic [31:0] csum,
                                    input bit gap, input bit hdr_err,
                                    input bit exp_done, input bit exp_err,
                                    input int exp_wr);
    vec_t v;
    v.hdr = hdr; v.nw = nw; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.csum = csum; v.gap = gap; v.hdr_err = hdr_err;
    v.exp_done = exp_done; v.exp_err = exp_err; v.exp_wr = exp_wr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    int t;
    n = gap ? int'($urandom_range(0, 5)) : 0;
    repeat (n) begin
      if (!bif.byte_ready_o) ready_ok = 1'b0;
      @(posedge clk); #1;
    end
    bif.byte_valid_i = 1'b1;
    bif.byte_i       = b;
    if (!bif.byte_ready_o) ready_ok = 1'b0;
    t = 0;
    while (!bif.byte_ready_o && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) tmo = 1'b1;
    else begin
      @(posedge clk); #1;
    end
    bif.byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic do_start();
    wa_q.delete();
    wd_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_done_clear", 32'(done), 32'd0);
    chk("start_err_clear", 32'(err), 32'd0);
    chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("start_ready", 32'(bif.byte_ready_o), 32'd1);
  endtask

  task automatic run_load(input vec_t v, input string tag);
    ready_ok = 1'b1;
    tmo      = 1'b0;
    do_start();
    send_word(v.hdr, v.gap);
    if (!v.hdr_err) begin
      for (int k = 0; k < v.nw; k++) send_word(v.w[k], v.gap);
`ifdef LOADER_CSUM_EN
      send_word(v.csum, v.gap);
`endif
    end
    chk({tag, "_timeout"}, 32'(tmo), 32'd0);
    chk({tag, "_ready_held"}, 32'(ready_ok), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'(v.exp_done));
    chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
    chk({tag, "_cpu_rst_t0"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_ready_off"}, 32'(bif.byte_ready_o), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_cpu_rst_t1"}, 32'(cpu_rst), v.exp_done ? 32'd0 : 32'd1);
    chk({tag, "_wr_en_idle"}, 32'(wr_en), 32'd0);
    chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(v.exp_wr));
    for (int k = 0; k < v.exp_wr && k < wa_q.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), wa_q[k], 32'(4 * k));
      chk($sformatf("%s_data%0d", tag, k), wd_q[k], v.w[k]);
    end
    if (v.exp_wr > 0) begin
      chk({tag, "_addr_hold"}, wr_addr, 32'(4 * (v.exp_wr - 1)));
      chk({tag, "_data_hold"}, wr_data, v.w[v.exp_wr - 1]);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, 32'h0);
    chk({tag, "_wr_data"}, wr_data, 32'h0);
    chk({tag, "_ready"}, 32'(bif.byte_ready_o), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
  endtask

  initial begin
    //                hdr         nw  w0            w1            w2            csum          gap herr done err wr
    vecs[0] = make_vec(32'd2,      2, 32'h00000013, 32'h00100093, 32'h0,        32'h001000A6, 0,  0,   1,   0,  2);
    vecs[1] = make_vec(32'd0,      0, 32'h0,        32'h0,        32'h0,        32'h00000000, 0,  0,   1,   0,  0);
    vecs[2] = make_vec(32'h1001,   0, 32'h0,        32'h0,        32'h0,        32'h0,        0,  1,   0,   1,  0);
    vecs[3] = make_vec(32'd1,      1, 32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF, 0,  0,   1,   0,  1);
    vecs[4] = make_vec(32'd3,      3, 32'h11223344, 32'hA5A55A5A, 32'hFFFFFFFF, 32'hB6C78D9D, 1,  0,   1,   0,  3);
    vecs[5] = make_vec(32'd3,      3, 32'h11223344, 32'hA5A55A5A, 32'hFFFFFFFF, 32'hB6C78D9D, 0,  0,   1,   0,  3);
`ifdef LOADER_CSUM_EN
    vecs[6] = make_vec(32'd2,      2, 32'h00000001, 32'h00000002, 32'h0,        32'h00000003, 0,  0,   1,   0,  2);
    vecs[7] = make_vec(32'd2,      2, 32'h00000001, 32'h00000002, 32'h0,        32'h00000004, 0,  0,   0,   1,  2);
`endif

    rst              = 1'b1;
    start            = 1'b0;
    bif.byte_valid_i = 1'b0;
    bif.byte_i       = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) run_load(vecs[i], $sformatf("vec%0d", i));

    // Reset after 6 payload bytes of an N=2 load: only word 0 lands.
    ready_ok = 1'b1;
    tmo      = 1'b0;
    do_start();
    send_word(32'd2, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_values("midrst");
    rst = 1'b0;
    chk("midrst_timeout", 32'(tmo), 32'd0);
    chk("midrst_nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() > 0) begin
      chk("midrst_addr0", wa_q[0], 32'h0);
      chk("midrst_data0", wd_q[0], 32'hCAFEF00D);
    end
    @(posedge clk); #1;
    run_load(vecs[0], "after_rst");

    // Full-depth image: N = ADDR_DEPTH is accepted.
    ready_ok = 1'b1;
    tmo      = 1'b0;
    do_start();
    send_word(32'h1000, 1'b0);
    for (int k = 0; k < 4096; k++) send_word(32'hA5000000 | 32'(k), 1'b0);
`ifdef LOADER_CSUM_EN
    send_word(32'h007FF800, 1'b0);
`endif
    chk("full_timeout", 32'(tmo), 32'd0);
    chk("full_done", 32'(done), 32'd1);
    chk("full_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    chk("full_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("full_nwrites", 32'(wa_q.size()), 32'd4096);
    if (wa_q.size() == 4096) begin
      chk("full_addr_last", wa_q[4095], 32'h00003FFC);
      chk("full_data_last", wd_q[4095], 32'hA5000FFF);
      chk("full_addr_mid", wa_q[1234], 32'h00001348);
      chk("full_data_mid", wd_q[1234], 32'hA50004D2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
